hazard_stall_ctrl: RTL and testbench

Parametrised hazard and stall controller for the 5-stage RV32I pipeline, sitting beside the IF/ID and ID/EX registers and driving PC write-enable, IF/ID write-enable, IF/ID flush and the control-bubble select. It extends single-cycle load-use and branch hazard detection with multi-cycle load latency, a data-memory freeze input, taken-branch flush priority and a selectable branch-resolve stage. It also adds stall-duration watchdog and saturating performance counters.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/hazard_detect.sv | 45 ++++
 rtl/hazard_stall_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RV32I hazard/stall control slice.
// Pure declarations: no logic, no latency, no flow control.
package pipe_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic lu;
        logic bh;
    } hazard_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and branch-operand hazard detection for the ID stage.
// Zero latency; no flow control of its own, the controller acts on its flags.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int BR_IN_ID  = 1,
    parameter int STORE_FWD = 1
) (
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic              id_is_store,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    output hazard_t           hz
);

    logic m1, m2, n1, n2;
    logic ex_rd_nz, mem_rd_nz;
    logic store_exempt;

    always_comb begin
        m1        = id_use_rs1 && (ex_rd == id_rs1);
        m2        = id_use_rs2 && (ex_rd == id_rs2);
        n1        = id_use_rs1 && (mem_rd == id_rs1);
        n2        = id_use_rs2 && (mem_rd == id_rs2);
        ex_rd_nz  = (ex_rd != '0);
        mem_rd_nz = (mem_rd != '0);

        // Store data needed only through rs2 can be forwarded at MEM, so no bubble.
        store_exempt = (STORE_FWD != 0) && id_is_store && m2 && !m1;

        hz.lu = ex_mem_read && ex_rd_nz && (m1 || m2) && !store_exempt;
        hz.bh = (BR_IN_ID != 0) && id_is_branch &&
                ((ex_reg_write && ex_rd_nz && (m1 || m2)) ||
                 (mem_mem_read && mem_rd_nz && (n1 || n2)));
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: PC/IF-ID enables, IF-ID flush, bubble select, freeze.
// Controls are same-cycle combinational; mem_busy freezes everything, br_taken flushes.
module hazard_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW    = REG_AW_DEF,
    parameter int LOAD_LAT  = 1,
    parameter int BR_IN_ID  = 1,
    parameter int STORE_FWD = 1,
    parameter int MAX_STALL = 64,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_branch,
    input  logic              id_is_store,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_mem_read,
    input  logic              mem_busy,
    input  logic              br_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              control_sel,
    output logic              if_id_flush,
    output logic              pipe_freeze,
    output logic              stall_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int HOLD_W = $clog2(LOAD_LAT + 1);
    localparam int RUN_W  = $clog2(MAX_STALL + 1);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(LOAD_LAT - 1);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_STALL);

    hazard_t hz;

    hz_state_e         state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic              stall_timeout_q, stall_timeout_d;

    logic is_freeze, is_flush, is_stall;

    hazard_detect #(
        .REG_AW    (REG_AW),
        .BR_IN_ID  (BR_IN_ID),
        .STORE_FWD (STORE_FWD)
    ) u_detect (
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_is_branch (id_is_branch),
        .id_is_store  (id_is_store),
        .ex_rd        (ex_rd),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .mem_rd       (mem_rd),
        .mem_mem_read (mem_mem_read),
        .hz           (hz)
    );

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        control_sel = 1'b1;
        if_id_flush = 1'b0;
        pipe_freeze = 1'b0;
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        is_freeze   = 1'b0;
        is_flush    = 1'b0;
        is_stall    = 1'b0;

        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
        end else if (mem_busy) begin
            // A frozen cycle leaves HOLD progress untouched so freezes extend the bubble 1:1.
            is_freeze   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (br_taken) begin
            is_flush    = 1'b1;
            if_id_flush = 1'b1;
            control_sel = 1'b0;
            state_d     = RUN;
            hold_cnt_d  = '0;
        end else if (state_q == HOLD || hz.lu || hz.bh) begin
            is_stall    = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            control_sel = 1'b0;
            if (state_q == HOLD) begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q == HOLD_W'(1)) begin
                    state_d = RUN;
                end
            end else if (hz.lu && (LOAD_LAT > 1)) begin
                state_d    = HOLD;
                hold_cnt_d = HOLD_INIT;
            end
        end
    end

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        flush_count_d   = flush_count_q;
        run_cnt_d       = '0;
        stall_timeout_d = stall_timeout_q || (run_cnt_q == RUN_MAX);

        if (is_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (is_flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
        // Watchdog run length parks at its limit instead of wrapping.
        if (is_stall || is_freeze) begin
            run_cnt_d = (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RUN;
            hold_cnt_q      <= '0;
            run_cnt_q       <= '0;
            stall_cycles_q  <= '0;
            flush_count_q   <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            run_cnt_q       <= run_cnt_d;
            stall_cycles_q  <= stall_cycles_d;
            flush_count_q   <= flush_count_d;
            stall_timeout_q <= stall_timeout_d;
        end
    end

    assign stall_timeout = stall_timeout_q;
    assign stall_cycles  = stall_cycles_q;
    assign flush_count   = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controller configurations share one random/directed stimulus stream;
// a reference model predicts each cycle's response and a monitor compares it.
module tb_hazard_stall_ctrl;

    localparam int LAT_A = 3, BRID_A = 1, SFWD_A = 1, MAXS_A = 8, CW_A = 6;
    localparam int LAT_B = 2, BRID_B = 0, SFWD_B = 0, MAXS_B = 5, CW_B = 5;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic       id_is_branch;
        logic       id_is_store;
        logic [4:0] ex_rd;
        logic       ex_reg_write;
        logic       ex_mem_read;
        logic [4:0] mem_rd;
        logic       mem_mem_read;
        logic       mem_busy;
        logic       br_taken;
    } stim_t;

    typedef struct {
        logic [4:0] comb;
        int         sc;
        int         fc;
        logic       to;
    } exp_t;

    logic  clk = 1'b0;
    stim_t s;

    logic            a_pc_write, a_if_id_write, a_control_sel, a_if_id_flush, a_pipe_freeze, a_to;
    logic [CW_A-1:0] a_sc, a_fc;
    logic            b_pc_write, b_if_id_write, b_control_sel, b_if_id_flush, b_pipe_freeze, b_to;
    logic [CW_B-1:0] b_sc, b_fc;
    logic [4:0]      comb_a, comb_b;

    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  qa[$];
    exp_t  qb[$];
    string cn[5] = '{"pc_write", "if_id_write", "control_sel", "if_id_flush", "pipe_freeze"};

    int cfg_lat [2] = '{LAT_A, LAT_B};
    int cfg_brid[2] = '{BRID_A, BRID_B};
    int cfg_sfwd[2] = '{SFWD_A, SFWD_B};
    int cfg_maxs[2] = '{MAXS_A, MAXS_B};
    int cfg_cmax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};

    int pend  [2];
    int runlen[2];
    int sc_m  [2];
    int fc_m  [2];
    bit to_m  [2];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .REG_AW(5), .LOAD_LAT(LAT_A), .BR_IN_ID(BRID_A), .STORE_FWD(SFWD_A),
        .MAX_STALL(MAXS_A), .CNT_W(CW_A)
    ) dut_a (
        .clk(clk), .rst_n(s.rst_n),
        .id_rs1(s.id_rs1), .id_rs2(s.id_rs2), .id_use_rs1(s.id_use_rs1), .id_use_rs2(s.id_use_rs2),
        .id_is_branch(s.id_is_branch), .id_is_store(s.id_is_store),
        .ex_rd(s.ex_rd), .ex_reg_write(s.ex_reg_write), .ex_mem_read(s.ex_mem_read),
        .mem_rd(s.mem_rd), .mem_mem_read(s.mem_mem_read), .mem_busy(s.mem_busy), .br_taken(s.br_taken),
        .pc_write(a_pc_write), .if_id_write(a_if_id_write), .control_sel(a_control_sel),
        .if_id_flush(a_if_id_flush), .pipe_freeze(a_pipe_freeze), .stall_timeout(a_to),
        .stall_cycles(a_sc), .flush_count(a_fc)
    );

    hazard_stall_ctrl #(
        .REG_AW(5), .LOAD_LAT(LAT_B), .BR_IN_ID(BRID_B), .STORE_FWD(SFWD_B),
        .MAX_STALL(MAXS_B), .CNT_W(CW_B)
    ) dut_b (
        .clk(clk), .rst_n(s.rst_n),
        .id_rs1(s.id_rs1), .id_rs2(s.id_rs2), .id_use_rs1(s.id_use_rs1), .id_use_rs2(s.id_use_rs2),
        .id_is_branch(s.id_is_branch), .id_is_store(s.id_is_store),
        .ex_rd(s.ex_rd), .ex_reg_write(s.ex_reg_write), .ex_mem_read(s.ex_mem_read),
        .mem_rd(s.mem_rd), .mem_mem_read(s.mem_mem_read), .mem_busy(s.mem_busy), .br_taken(s.br_taken),
        .pc_write(b_pc_write), .if_id_write(b_if_id_write), .control_sel(b_control_sel),
        .if_id_flush(b_if_id_flush), .pipe_freeze(b_pipe_freeze), .stall_timeout(b_to),
        .stall_cycles(b_sc), .flush_count(b_fc)
    );

    assign comb_a = {a_pc_write, a_if_id_write, a_control_sel, a_if_id_flush, a_pipe_freeze};
    assign comb_b = {b_pc_write, b_if_id_write, b_control_sel, b_if_id_flush, b_pipe_freeze};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: a load-use owes LOAD_LAT bubbles; pend is the number still owed after this cycle.
    task automatic model_step(input int k, input stim_t t, output exp_t e);
        bit m1, m2, n1, n2, lu, bh, to_next;
        e.comb = 5'b00000;
        if (!t.rst_n) begin
            pend[k] = 0; runlen[k] = 0; sc_m[k] = 0; fc_m[k] = 0; to_m[k] = 0;
        end else begin
            m1 = t.id_use_rs1 && (t.ex_rd == t.id_rs1);
            m2 = t.id_use_rs2 && (t.ex_rd == t.id_rs2);
            n1 = t.id_use_rs1 && (t.mem_rd == t.id_rs1);
            n2 = t.id_use_rs2 && (t.mem_rd == t.id_rs2);
            lu = t.ex_mem_read && (t.ex_rd != 0) && (m1 || m2) &&
                 !((cfg_sfwd[k] != 0) && t.id_is_store && m2 && !m1);
            bh = (cfg_brid[k] != 0) && t.id_is_branch &&
                 ((t.ex_reg_write && (t.ex_rd != 0) && (m1 || m2)) ||
                  (t.mem_mem_read && (t.mem_rd != 0) && (n1 || n2)));
            to_next = to_m[k] || (runlen[k] >= cfg_maxs[k]);
            if (t.mem_busy) begin
                e.comb = 5'b00101;
                runlen[k] = (runlen[k] < cfg_maxs[k]) ? runlen[k] + 1 : cfg_maxs[k];
            end else if (t.br_taken) begin
                e.comb = 5'b11010;
                pend[k] = 0;
                runlen[k] = 0;
                if (fc_m[k] < cfg_cmax[k]) fc_m[k]++;
            end else if (pend[k] > 0 || lu || bh) begin
                e.comb = 5'b00000;
                if (sc_m[k] < cfg_cmax[k]) sc_m[k]++;
                runlen[k] = (runlen[k] < cfg_maxs[k]) ? runlen[k] + 1 : cfg_maxs[k];
                if (pend[k] > 0) pend[k]--;
                else if (lu) pend[k] = cfg_lat[k] - 1;
            end else begin
                e.comb = 5'b11100;
                runlen[k] = 0;
            end
            to_m[k] = to_next;
        end
        e.sc = sc_m[k];
        e.fc = fc_m[k];
        e.to = to_m[k];
    endtask

    function automatic stim_t idle();
        stim_t t = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    task automatic apply(input stim_t st, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s = st;
            model_step(0, st, e);
            qa.push_back(e);
            model_step(1, st, e);
            qb.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t ea, eb;
        forever begin
            @(negedge clk);
            #2;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa[0];
                eb = qb[0];
                for (int b = 0; b < 5; b++) begin
                    check({"A.", cn[b]}, int'(comb_a[4-b]), int'(ea.comb[4-b]));
                    check({"B.", cn[b]}, int'(comb_b[4-b]), int'(eb.comb[4-b]));
                end
                @(posedge clk);
                #1;
                check("A.stall_cycles", int'(a_sc), ea.sc);
                check("A.flush_count", int'(a_fc), ea.fc);
                check("A.stall_timeout", int'(a_to), int'(ea.to));
                check("B.stall_cycles", int'(b_sc), eb.sc);
                check("B.flush_count", int'(b_fc), eb.fc);
                check("B.stall_timeout", int'(b_to), int'(eb.to));
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
        end
    end

    initial begin : driver
        stim_t st;
        int    busy_left;
        s = '0;
        st = idle(); st.rst_n = 1'b0; apply(st, 2);
        st = idle(); apply(st, 2);

        // load-use on rs1, operands held while the pipe is stalled
        st = idle(); st.ex_mem_read = 1; st.ex_rd = 5; st.id_rs1 = 5; st.id_use_rs1 = 1;
        apply(st, 3);
        st = idle(); apply(st, 2);

        // store whose only dependence is rs2
        st = idle(); st.id_is_store = 1; st.id_use_rs1 = 1; st.id_use_rs2 = 1;
        st.id_rs1 = 2; st.id_rs2 = 7; st.ex_rd = 7; st.ex_mem_read = 1;
        apply(st, 1);
        st = idle(); apply(st, 3);

        // branch operand from EX, then rd=0, then from a load in MEM
        st = idle(); st.id_is_branch = 1; st.id_use_rs1 = 1; st.id_use_rs2 = 1;
        st.id_rs2 = 9; st.ex_rd = 9; st.ex_reg_write = 1;
        apply(st, 1);
        st.ex_rd = 0; st.id_rs2 = 0; apply(st, 1);
        st = idle(); st.id_is_branch = 1; st.id_use_rs1 = 1; st.id_rs1 = 4;
        st.mem_rd = 4; st.mem_mem_read = 1;
        apply(st, 1);
        st = idle(); apply(st, 2);

        // taken branch arriving mid-HOLD
        st = idle(); st.ex_mem_read = 1; st.ex_rd = 5; st.id_rs1 = 5; st.id_use_rs1 = 1;
        apply(st, 1);
        st = idle(); st.br_taken = 1; apply(st, 1);
        st = idle(); apply(st, 2);

        // freeze in the middle of a load-use
        st = idle(); st.ex_mem_read = 1; st.ex_rd = 6; st.id_rs2 = 6; st.id_use_rs2 = 1;
        apply(st, 1);
        st.mem_busy = 1; apply(st, 4);
        st.mem_busy = 0; apply(st, 2);
        st = idle(); apply(st, 2);

        // watchdog trip, busy+branch overlap, then reset clears the sticky flag
        st = idle(); st.mem_busy = 1; apply(st, 10);
        st.br_taken = 1; apply(st, 2);
        st.mem_busy = 0; apply(st, 1);
        st = idle(); apply(st, 3);
        st.rst_n = 0; apply(st, 1);
        st = idle(); apply(st, 2);

        // mid-HOLD reset
        st = idle(); st.ex_mem_read = 1; st.ex_rd = 3; st.id_rs1 = 3; st.id_use_rs1 = 1;
        apply(st, 1);
        st = idle(); st.rst_n = 0; apply(st, 1);
        st = idle(); apply(st, 2);

        busy_left = 0;
        for (int i = 0; i < 3000; i++) begin
            st.rst_n        = ($urandom_range(0, 399) != 0);
            st.id_rs1       = 5'($urandom_range(0, 3));
            st.id_rs2       = 5'($urandom_range(0, 3));
            st.id_use_rs1   = 1'($urandom_range(0, 1));
            st.id_use_rs2   = 1'($urandom_range(0, 1));
            st.id_is_branch = ($urandom_range(0, 3) == 0);
            st.id_is_store  = ($urandom_range(0, 3) == 0);
            st.ex_rd        = 5'($urandom_range(0, 3));
            st.ex_reg_write = 1'($urandom_range(0, 1));
            st.ex_mem_read  = ($urandom_range(0, 2) == 0);
            st.mem_rd       = 5'($urandom_range(0, 3));
            st.mem_mem_read = ($urandom_range(0, 2) == 0);
            st.br_taken     = ($urandom_range(0, 11) == 0);
            if (busy_left == 0 && $urandom_range(0, 149) == 0) busy_left = $urandom_range(4, 12);
            st.mem_busy     = (busy_left > 0) || ($urandom_range(0, 9) == 0);
            if (busy_left > 0) busy_left--;
            apply(st, 1);
        end

        for (int w = 0; w < 20 && qa.size() > 0; w++) @(posedge clk);
        if (qa.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations still pending, expected 0", qa.size());
        end
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
